// File: rtl/key256_schedule_ctrl_if.sv
// Handshake and datapath bus for the AES-256 round-key sequencer.
// slave: the sequencer. master: the key requester, the consumer and the
// external single-round expansion datapath.
interface key256_schedule_ctrl_if;
  logic         start;
  logic [255:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy;
  logic         done;
  logic [3:0]   exp_round_no;
  logic [255:0] exp_before;
  logic [255:0] exp_after;

  modport slave (
    input  start, key_in, rk_ready, exp_after,
    output rk_valid, rk_idx, rk_out, busy, done, exp_round_no, exp_before
  );

  modport master (
    output start, key_in, rk_ready, exp_after,
    input  rk_valid, rk_idx, rk_out, busy, done, exp_round_no, exp_before
  );
endinterface

// File: rtl/key256_schedule_ctrl.sv
// AES-256 key schedule sequencer. It holds an 8-word window of the expanded
// key and emits it as two 128-bit round keys (upper half, then lower half)
// under a valid/ready handshake. After each lower-half handshake the window
// advances by one expansion round through the external datapath. Seven
// window updates yield round keys 0..14. Key 14 is the upper half of the
// last window, so the lower half of that window is never emitted.
module key256_schedule_ctrl (
  input logic                 clk,
  input logic                 rst,
  key256_schedule_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT_HI = 2'd1,
    EMIT_LO = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'd14;
  localparam logic [2:0] LAST_ROUND = 3'd7;

  state_t       state_reg, state_next;
  logic [255:0] window_reg, window_next;
  logic [2:0]   round_reg, round_next;
  logic [3:0]   idx_reg, idx_next;
  logic         emitting;
  logic         handshake;

  assign emitting  = (state_reg == EMIT_HI) || (state_reg == EMIT_LO);
  assign handshake = emitting && bus.rk_ready;

  // State, window, round counter and key index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      window_reg <= '0;
      round_reg  <= '0;
      idx_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      window_reg <= window_next;
      round_reg  <= round_next;
      idx_reg    <= idx_next;
    end
  end

  // Next-state logic: accept start only from IDLE, advance on handshakes
  always_comb begin
    state_next  = state_reg;
    window_next = window_reg;
    round_next  = round_reg;
    idx_next    = idx_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          window_next = bus.key_in;
          round_next  = 3'd1;
          idx_next    = 4'd0;
          state_next  = EMIT_HI;
        end
      end
      EMIT_HI: begin
        if (handshake) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 4'd1;
            state_next = EMIT_LO;
          end
        end
      end
      EMIT_LO: begin
        if (handshake) begin
          window_next = bus.exp_after;
          // The seventh update feeds key 14, which still belongs to round 7.
          if (round_reg != LAST_ROUND) begin
            round_next = round_reg + 3'd1;
          end
          idx_next   = idx_reg + 4'd1;
          state_next = EMIT_HI;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    bus.rk_valid     = emitting;
    bus.rk_idx       = idx_reg;
    bus.rk_out       = (state_reg == EMIT_LO) ? window_reg[127:0] : window_reg[255:128];
    bus.busy         = (state_reg != IDLE);
    bus.done         = (state_reg == DONE);
    bus.exp_round_no = emitting ? {1'b0, round_reg} : 4'd0;
    bus.exp_before   = window_reg;
  end
endmodule

// File: tb/tb_key256_schedule_ctrl.sv
// Bench for key256_schedule_ctrl. Supplies the external expansion datapath,
// checks every emitted key against a full FIPS-197 AES-256 key expansion,
// and runs table vectors, handshake back-pressure, restart, reset-abort and
// back-to-back scenarios.
module tb_key256_schedule_ctrl;
  logic clk = 1'b0;
  logic rst;

  key256_schedule_ctrl_if bus ();

  key256_schedule_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] got   [15];
  logic [31:0]  ref_w [64];

  typedef struct {
    logic [255:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs [5];

  localparam logic [255:0] K_SEQ =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  // GF(2^8) arithmetic and S-box
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, v);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // External single-round expansion datapath: window r -> window r+1
  function automatic logic [255:0] dp_step(input logic [255:0] win, input logic [3:0] r);
    logic [31:0]  w [8];
    logic [31:0]  n [8];
    logic [255:0] res;
    logic [7:0]   rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = win[255-32*i -: 32];
    for (int i = 1; i < int'(r); i++) rc = xtime(rc);
    n[0] = w[0] ^ sub_word(rot_word(w[7])) ^ {rc, 24'h0};
    for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i-1];
    n[4] = w[4] ^ sub_word(n[3]);
    for (int i = 5; i < 8; i++) n[i] = w[i] ^ n[i-1];
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = n[i];
    return res;
  endfunction

  always_comb bus.exp_after = dp_step(bus.exp_before, bus.exp_round_no);

  // Reference: textbook word-by-word AES-256 expansion (64 words)
  task automatic build_ref(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) ref_w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 64; i++) begin
      t = ref_w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word(rot_word(t)) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      ref_w[i] = ref_w[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_of(input int k);
    return {ref_w[4*k], ref_w[4*k+1], ref_w[4*k+2], ref_w[4*k+3]};
  endfunction

  function automatic logic [255:0] win_of(input int p);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = ref_w[8*p+i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // One full schedule starting at a negedge with the DUT in IDLE.
  // restart_idx / rst_idx: key index at which to pulse start / rst (-1 = never).
  // hold: keep start high throughout (back-to-back mode).
  task automatic run_schedule(input logic [255:0] key, input int ready_pct,
                              input int restart_idx, input int rst_idx, input bit hold);
    int           next_k      = 0;
    int           cycles      = 0;
    bit           expect_done = 1'b0;
    bit           prev_stall  = 1'b0;
    bit           restarted   = 1'b0;
    logic [127:0] prev_out    = '0;
    logic [3:0]   prev_idx    = '0;
    build_ref(key);
    for (int i = 0; i < 15; i++) got[i] = '0;
    bus.key_in   = key;
    bus.start    = 1'b1;
    bus.rk_ready = 1'b0;
    @(negedge clk);
    cycles    = 1;
    bus.start = hold;
    while (1) begin
      if (cycles > 400) begin
        errors++;
        checks++;
        $display("FAIL timeout act=%0d cycles exp=done within 400", cycles);
        break;
      end
      if (expect_done) begin
        chk("done_pulse", 256'(bus.done), 256'(1));
        chk("done_no_key", 256'(bus.rk_valid), 256'(0));
        chk("done_round_no", 256'(bus.exp_round_no), 256'(0));
        if (ready_pct >= 100) chk("done_latency", 256'(cycles), 256'(16));
        @(negedge clk);
        chk("after_done", 256'(bus.done), 256'(0));
        chk("after_busy", 256'(bus.busy), 256'(0));
        chk("after_valid", 256'(bus.rk_valid), 256'(0));
        if (!hold) chk("idle_window", bus.exp_before, win_of(7));
        break;
      end
      chk("valid", 256'(bus.rk_valid), 256'(1));
      chk("busy", 256'(bus.busy), 256'(1));
      if (prev_stall) begin
        chk("stable_out", 256'(bus.rk_out), 256'(prev_out));
        chk("stable_idx", 256'(bus.rk_idx), 256'(prev_idx));
      end
      chk("idx_order", 256'(bus.rk_idx), 256'(next_k));
      chk("rk", 256'(bus.rk_out), 256'(rk_of(next_k)));
      chk("round_no", 256'(bus.exp_round_no), 256'((next_k < 14) ? next_k / 2 + 1 : 7));
      chk("window", bus.exp_before, win_of(next_k / 2));
      bus.rk_ready = ($urandom_range(0, 99) < ready_pct);
      if (rst_idx >= 0 && int'(bus.rk_idx) == rst_idx) begin
        rst          = 1'b1;
        bus.rk_ready = 1'b1;
        bus.start    = 1'b1;
        @(negedge clk);
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_valid", 256'(bus.rk_valid), 256'(0));
        chk("rst_round_no", 256'(bus.exp_round_no), 256'(0));
        chk("rst_idx", 256'(bus.rk_idx), 256'(0));
        chk("rst_window", bus.exp_before, 256'(0));
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 256'(bus.done), 256'(0));
        $display("schedule aborted by reset at idx=%0d", rst_idx);
        return;
      end
      if (!restarted && int'(bus.rk_idx) == restart_idx) begin
        bus.start  = 1'b1;
        bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
        restarted  = 1'b1;
      end
      prev_stall = !bus.rk_ready;
      prev_out   = bus.rk_out;
      prev_idx   = bus.rk_idx;
      if (bus.rk_ready) begin
        got[next_k] = bus.rk_out;
        $display("hs idx=%0d rk=%h", next_k, bus.rk_out);
        if (next_k == 14) expect_done = 1'b1;
        else next_k++;
      end
      @(negedge clk);
      cycles++;
      bus.start = hold;
    end
  endtask

  initial begin
    logic [255:0] k;
    vecs[0] = '{key: K_SEQ, idx: 0,  rk: 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{key: K_SEQ, idx: 1,  rk: 128'h101112131415161718191a1b1c1d1e1f};
    vecs[2] = '{key: K_SEQ, idx: 2,  rk: 128'ha573c29fa176c498a97fce93a572c09c};
    vecs[3] = '{key: K_SEQ, idx: 14, rk: 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[4] = '{key: '0,    idx: 2,  rk: 128'h62636363626363636263636362636363};

    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.key_in   = K_SEQ;
    bus.rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 256'(bus.busy), 256'(0));
    chk("reset_valid", 256'(bus.rk_valid), 256'(0));
    chk("reset_done", 256'(bus.done), 256'(0));
    chk("reset_idx", 256'(bus.rk_idx), 256'(0));
    chk("reset_rk_out", 256'(bus.rk_out), 256'(0));
    chk("reset_round_no", 256'(bus.exp_round_no), 256'(0));
    chk("reset_window", bus.exp_before, 256'(0));
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start_busy", 256'(bus.busy), 256'(0));
    chk("idle_no_start_window", bus.exp_before, 256'(0));

    for (int v = 0; v < 5; v++) begin
      run_schedule(vecs[v].key, 100, -1, -1, 1'b0);
      chk("vector", 256'(got[vecs[v].idx]), 256'(vecs[v].rk));
    end

    run_schedule(K_SEQ, 50, -1, -1, 1'b0);
    chk("toggle_rk14", 256'(got[14]), 256'(vecs[3].rk));

    run_schedule(K_SEQ, 100, 5, -1, 1'b0);
    run_schedule(K_SEQ, 60, 5, -1, 1'b0);
    chk("restart_rk14", 256'(got[14]), 256'(vecs[3].rk));

    run_schedule(K_SEQ, 70, -1, 9, 1'b0);
    k = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    run_schedule(k, 100, -1, -1, 1'b0);
    chk("post_reset_rk0", 256'(got[0]), 256'(k[255:128]));

    run_schedule(K_SEQ, 100, -1, -1, 1'b1);
    run_schedule('0, 100, -1, -1, 1'b1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_end_idle", 256'(bus.busy), 256'(0));

    for (int r = 0; r < 8; r++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      run_schedule(k, $urandom_range(30, 100), -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
